// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam logic [7:0] DEF_DATA_BASE      = 8'hC0;
    localparam int         DEF_TIMEOUT_CYCLES = 255;

    localparam logic [3:0] BYTEEN_ALL  = 4'b1111;
    localparam logic [3:0] BYTEEN_NONE = 4'b0000;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        logic [3:0] onehot;
        case (lane)
            LANE_0:  onehot = 4'b0001;
            LANE_1:  onehot = 4'b0010;
            LANE_2:  onehot = 4'b0100;
            LANE_3:  onehot = 4'b1000;
            default: onehot = 4'b0001;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// Byte-lane steering between the 8-bit data requester and the 32-bit memory word.
module byte_lane_sel
    import mem_arb_pkg::*;
(
    input  logic [7:0]  wr_byte,
    input  logic [1:0]  wr_lane,
    input  logic        wr_en,
    input  logic [31:0] rd_word,
    input  logic [1:0]  rd_lane,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en,
    output logic [7:0]  rd_byte
);

    assign wr_word = {4{wr_byte}};

    // A data write touches only its lane; everything else moves the full word.
    always_comb begin
        if (wr_en) begin
            byte_en = lane_onehot(wr_lane);
        end else begin
            byte_en = BYTEEN_ALL;
        end
    end

    // Extract the addressed byte from the captured word.
    always_comb begin
        case (rd_lane)
            LANE_0:  rd_byte = rd_word[7:0];
            LANE_1:  rd_byte = rd_word[15:8];
            LANE_2:  rd_byte = rd_word[23:16];
            LANE_3:  rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single shared memory port.
// Optional access watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [7:0] DATA_BASE      = DEF_DATA_BASE,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_READDATA,
    output logic        I_BUSYWAIT,
    input  logic        D_READ,
    input  logic        D_WRITE,
    input  logic [7:0]  D_ADDR,
    input  logic [7:0]  D_WRITEDATA,
    output logic [7:0]  D_READDATA,
    output logic        D_BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [7:0]  MEM_ADDR,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTEEN,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic        ERR
);

    arb_state_e  state_r;
    arb_owner_e  own_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [7:0]  mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_byteen_r;
    logic [31:0] word_r;
    logic [1:0]  d_lane_r;

    logic        d_req_s;
    logic        done_s;
    logic [7:0]  d_mem_addr_s;
    logic [31:0] wr_word_s;
    logic [3:0]  byte_en_s;
    logic [7:0]  rd_byte_s;
    logic        unused_s;

    assign d_req_s      = D_READ | D_WRITE;
    assign d_mem_addr_s = DATA_BASE + {2'b00, D_ADDR[7:2]};

    // Reset makes the handshake look like IDLE even if the state register still says DONE.
    assign done_s     = (state_r == ST_DONE) && !RESET;
    assign I_BUSYWAIT = I_READ & ~(done_s & (own_r == OWN_I));
    assign D_BUSYWAIT = d_req_s & ~(done_s & (own_r == OWN_D));

    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDR      = mem_addr_r;
    assign MEM_WRITEDATA = mem_wdata_r;
    assign MEM_BYTEEN    = mem_byteen_r;
    assign I_READDATA    = word_r;
    assign D_READDATA    = rd_byte_s;

    byte_lane_sel u_lane (
        .wr_byte (D_WRITEDATA),
        .wr_lane (D_ADDR[1:0]),
        .wr_en   (D_WRITE),
        .rd_word (word_r),
        .rd_lane (d_lane_r),
        .wr_word (wr_word_s),
        .byte_en (byte_en_s),
        .rd_byte (rd_byte_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_r;
    logic       err_r;

    assign ERR      = err_r;
    assign unused_s = ^{I_ADDR[31:10], I_ADDR[1:0]};
`else
    assign ERR      = 1'b0;
    assign unused_s = ^{I_ADDR[31:10], I_ADDR[1:0], 8'(TIMEOUT_CYCLES)};
`endif

    // Sequencer: choose an owner in IDLE (data wins ties), hold the access until memory releases it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            own_r        <= OWN_I;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 8'h00;
            mem_wdata_r  <= 32'h0000_0000;
            mem_byteen_r <= BYTEEN_NONE;
            word_r       <= 32'h0000_0000;
            d_lane_r     <= LANE_0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_r    <= 8'd0;
            err_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (d_req_s) begin
                        state_r      <= ST_ACCESS;
                        own_r        <= OWN_D;
                        mem_read_r   <= ~D_WRITE;
                        mem_write_r  <= D_WRITE;
                        mem_addr_r   <= d_mem_addr_s;
                        mem_wdata_r  <= D_WRITE ? wr_word_s : 32'h0000_0000;
                        mem_byteen_r <= byte_en_s;
                        // Only a data read redirects the byte returned to the data side.
                        if (!D_WRITE) begin
                            d_lane_r <= D_ADDR[1:0];
                        end
                    end else if (I_READ) begin
                        state_r      <= ST_ACCESS;
                        own_r        <= OWN_I;
                        mem_read_r   <= 1'b1;
                        mem_write_r  <= 1'b0;
                        mem_addr_r   <= I_ADDR[9:2];
                        mem_wdata_r  <= 32'h0000_0000;
                        mem_byteen_r <= BYTEEN_ALL;
                    end
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_r <= 8'd0;
`endif
                end
                ST_ACCESS: begin
                    if (!MEM_BUSYWAIT) begin
                        state_r     <= ST_DONE;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        if (mem_read_r) begin
                            word_r <= MEM_READDATA;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        state_r     <= ST_DONE;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        word_r      <= 32'h0000_0000;
                        err_r       <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        I_READ = 1'b0, I_BUSYWAIT;
    logic [31:0] I_ADDR = 32'h0, I_READDATA;
    logic        D_READ = 1'b0, D_WRITE = 1'b0, D_BUSYWAIT;
    logic [7:0]  D_ADDR = 8'h0, D_WRITEDATA = 8'h0, D_READDATA;
    logic        MEM_READ, MEM_WRITE, ERR;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTEEN;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;

    // second instance with DATA_BASE=FF for the address wrap case
    logic        w_i_read = 1'b0, w_d_read = 1'b0, w_d_write = 1'b0, w_mem_busy = 1'b0;
    logic [31:0] w_i_addr = 32'h0, w_mem_rdata = 32'h0;
    logic [7:0]  w_d_addr = 8'h04, w_d_wd = 8'h00;
    logic        w_i_busy, w_d_busy, w_mem_read, w_mem_write, w_err;
    logic [31:0] w_i_rdata, w_mem_wd;
    logic [7:0]  w_d_rdata, w_mem_addr;
    logic [3:0]  w_mem_be;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.DATA_BASE(8'hC0), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTEEN(MEM_BYTEEN),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .ERR(ERR)
    );

    mem_port_arbiter #(.DATA_BASE(8'hFF), .TIMEOUT_CYCLES(TMO)) dut_wrap (
        .CLK(CLK), .RESET(RESET),
        .I_READ(w_i_read), .I_ADDR(w_i_addr), .I_READDATA(w_i_rdata), .I_BUSYWAIT(w_i_busy),
        .D_READ(w_d_read), .D_WRITE(w_d_write), .D_ADDR(w_d_addr), .D_WRITEDATA(w_d_wd),
        .D_READDATA(w_d_rdata), .D_BUSYWAIT(w_d_busy),
        .MEM_READ(w_mem_read), .MEM_WRITE(w_mem_write), .MEM_ADDR(w_mem_addr),
        .MEM_WRITEDATA(w_mem_wd), .MEM_BYTEEN(w_mem_be),
        .MEM_READDATA(w_mem_rdata), .MEM_BUSYWAIT(w_mem_busy), .ERR(w_err)
    );

    int checks = 0;
    int errors = 0;

    // requesters and fixed-value overrides
    bit          rq_i, rq_d, rq_drd, rq_dwr, use_fx;
    logic [31:0] fx_iaddr, fx_rdata;
    logic [7:0]  fx_daddr, fx_dwd;
    int          nxt_wait;

    // reference model: one transaction at a time described by its cycle timeline
    int          cyc = 0, m_beg = 0, m_len = 0, m_wait = 0;
    bit          m_active, m_own_d, m_wr, m_tmo, m_err;
    logic [7:0]  m_addr = 8'h0;
    logic [31:0] m_wd = 32'h0, m_word = 32'h0;
    logic [3:0]  m_be = 4'h0;
    logic [1:0]  m_lane = 2'd0;

    bit          e_valid, e_acc, e_rd, e_wr, e_ib, e_db, e_dchk, e_err;
    logic [7:0]  e_addr, e_dbyte;
    logic [31:0] e_wd, e_word;
    logic [3:0]  e_be;

    logic        s_mem_read, s_mem_write, s_ib, s_db, s_err, s_w_read;
    logic [7:0]  s_addr, s_drd, s_w_addr;
    logic [31:0] s_wd, s_ird;
    logic [3:0]  s_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Compare process: DUT outputs against the model at every falling edge.
    always @(negedge CLK) begin
        s_mem_read <= MEM_READ; s_mem_write <= MEM_WRITE; s_addr <= MEM_ADDR;
        s_wd <= MEM_WRITEDATA; s_be <= MEM_BYTEEN; s_ib <= I_BUSYWAIT; s_db <= D_BUSYWAIT;
        s_ird <= I_READDATA; s_drd <= D_READDATA; s_err <= ERR;
        s_w_read <= w_mem_read; s_w_addr <= w_mem_addr;
        if (e_valid) begin
            chk("mem_read", MEM_READ, e_rd);
            chk("mem_write", MEM_WRITE, e_wr);
            chk("i_busywait", I_BUSYWAIT, e_ib);
            chk("d_busywait", D_BUSYWAIT, e_db);
            chk("i_readdata", I_READDATA, e_word);
            chk("err", ERR, e_err);
            if (e_acc) begin
                chk("mem_addr", MEM_ADDR, e_addr);
                chk("mem_byteen", MEM_BYTEEN, e_be);
                if (e_wr) chk("mem_writedata", MEM_WRITEDATA, e_wd);
            end
            if (e_dchk) chk("d_readdata", D_READDATA, e_dbyte);
        end
    end

    task automatic step(input bit rst, input bit cmp);
        bit acc, done;
        RESET   = rst;
        I_READ  = rq_i;
        D_READ  = rq_d && rq_drd;
        D_WRITE = rq_d && rq_dwr;
        if (use_fx) begin
            I_ADDR = fx_iaddr; D_ADDR = fx_daddr; D_WRITEDATA = fx_dwd; MEM_READDATA = fx_rdata;
        end else begin
            I_ADDR = $urandom; D_ADDR = 8'($urandom); D_WRITEDATA = 8'($urandom); MEM_READDATA = $urandom;
        end
        acc  = m_active && (cyc >= m_beg) && (cyc < m_beg + m_len);
        done = m_active && (cyc == m_beg + m_len);
        if (acc) MEM_BUSYWAIT = ((cyc - m_beg) < m_wait);
        else     MEM_BUSYWAIT = 1'($urandom_range(0, 1));
        e_valid = cmp; e_acc = acc; e_rd = acc && !m_wr; e_wr = acc && m_wr;
        e_addr = m_addr; e_wd = m_wd; e_be = m_be;
        e_ib = I_READ && !(done && !m_own_d && !rst);
        e_db = (D_READ || D_WRITE) && !(done && m_own_d && !rst);
        e_word = m_word; e_dchk = done && m_own_d && !m_wr;
        e_dbyte = 8'(m_word >> (8 * m_lane)); e_err = m_err;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        if (rst) begin
            m_active = 1'b0; m_word = 32'h0; m_err = 1'b0; m_lane = 2'd0;
        end else begin
            if (acc && (cyc == m_beg + m_len - 1)) begin
                if (m_tmo) begin m_word = 32'h0; m_err = 1'b1; end
                else if (!m_wr) m_word = MEM_READDATA;
            end
            if (done) begin
                m_active = 1'b0;
                if (m_own_d) rq_d = 1'b0; else rq_i = 1'b0;
            end else if (!m_active && (I_READ || D_READ || D_WRITE)) begin
                m_active = 1'b1; m_beg = cyc + 1;
                m_own_d = D_READ || D_WRITE;
                m_wr = m_own_d && D_WRITE;
                if (m_own_d) begin
                    m_addr = 8'((192 + D_ADDR / 4) % 256);
                    m_be = m_wr ? 4'(1 << (D_ADDR % 4)) : 4'b1111;
                    m_wd = {4{D_WRITEDATA}};
                    if (!m_wr) m_lane = 2'(D_ADDR % 4);
                end else begin
                    m_addr = 8'((I_ADDR / 4) % 256);
                    m_be = 4'b1111;
                end
                m_wait = nxt_wait;
`ifdef ARB_TIMEOUT_EN
                m_tmo = (m_wait >= TMO);
                m_len = m_tmo ? TMO : m_wait + 1;
`else
                m_tmo = 1'b0;
                m_len = m_wait + 1;
`endif
            end
        end
        cyc++;
    endtask

    initial begin
        bit pend;
        use_fx = 1'b1; fx_iaddr = 32'h0; fx_daddr = 8'h0; fx_dwd = 8'h0; fx_rdata = 32'h0;
        nxt_wait = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_mem_read", s_mem_read, 32'd0);
        chk("rst_mem_write", s_mem_write, 32'd0);
        chk("rst_mem_addr", s_addr, 32'h00);
        chk("rst_mem_wdata", s_wd, 32'h0);
        chk("rst_mem_byteen", s_be, 32'h0);
        chk("rst_i_readdata", s_ird, 32'h0);

        // zero-wait fetch, plus the wrap instance in the same cycles
        fx_iaddr = 32'h8; fx_rdata = 32'hDEADBEEF; rq_i = 1'b1; w_d_read = 1'b1;
        step(1'b0, 1'b1); chk("f_c0_ibusy", s_ib, 32'd1);
        w_d_read = 1'b0;
        step(1'b0, 1'b1); chk("f_c1_read", s_mem_read, 32'd1); chk("f_c1_addr", s_addr, 32'h02);
        chk("wrap_read", s_w_read, 32'd1); chk("wrap_addr", s_w_addr, 32'h00);
        step(1'b0, 1'b1); chk("f_c2_ibusy", s_ib, 32'd0); chk("f_c2_rdata", s_ird, 32'hDEADBEEF);
        step(1'b0, 1'b1);

        // data write with three wait cycles
        rq_d = 1'b1; rq_drd = 1'b0; rq_dwr = 1'b1; fx_daddr = 8'h05; fx_dwd = 8'hAB; nxt_wait = 3;
        step(1'b0, 1'b1); chk("w_c0_dbusy", s_db, 32'd1);
        step(1'b0, 1'b1);
        chk("w_c1_write", s_mem_write, 32'd1); chk("w_c1_read", s_mem_read, 32'd0);
        chk("w_c1_addr", s_addr, 32'hC1); chk("w_c1_be", s_be, 32'b0010);
        chk("w_c1_wdata", s_wd, 32'hABABABAB);
        for (int k = 2; k <= 4; k++) begin
            step(1'b0, 1'b1); chk("w_wait_dbusy", s_db, 32'd1);
        end
        step(1'b0, 1'b1); chk("w_c5_dbusy", s_db, 32'd0);
        step(1'b0, 1'b1);

        // simultaneous requests: data first, one idle cycle, then fetch
        rq_i = 1'b1; rq_d = 1'b1; rq_drd = 1'b1; rq_dwr = 1'b0;
        fx_iaddr = 32'h40; fx_daddr = 8'h0A; fx_rdata = 32'h11223344; nxt_wait = 0;
        step(1'b0, 1'b1); chk("t_c0_ibusy", s_ib, 32'd1); chk("t_c0_dbusy", s_db, 32'd1);
        step(1'b0, 1'b1); chk("t_c1_read", s_mem_read, 32'd1); chk("t_c1_addr", s_addr, 32'hC2);
        step(1'b0, 1'b1); chk("t_c2_dbusy", s_db, 32'd0); chk("t_c2_ibusy", s_ib, 32'd1);
        chk("t_c2_dbyte", s_drd, 32'h22);
        step(1'b0, 1'b1); chk("t_c3_idle_read", s_mem_read, 32'd0); chk("t_c3_ibusy", s_ib, 32'd1);
        step(1'b0, 1'b1); chk("t_c4_read", s_mem_read, 32'd1); chk("t_c4_addr", s_addr, 32'h10);
        step(1'b0, 1'b1); chk("t_c5_ibusy", s_ib, 32'd0); chk("t_c5_rdata", s_ird, 32'h11223344);
        step(1'b0, 1'b1);

        // reset during the second access cycle, then the fetch is retried
        rq_i = 1'b1; fx_iaddr = 32'h100; fx_rdata = 32'hCAFE0001; nxt_wait = 3;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1); chk("r_c1_read", s_mem_read, 32'd1);
        nxt_wait = 0;
        step(1'b1, 1'b1); chk("r_c2_ibusy", s_ib, 32'd1);
        step(1'b0, 1'b1);
        chk("r_c3_read", s_mem_read, 32'd0); chk("r_c3_addr", s_addr, 32'h00);
        chk("r_c3_be", s_be, 32'h0); chk("r_c3_word", s_ird, 32'h0); chk("r_c3_ibusy", s_ib, 32'd1);
        step(1'b0, 1'b1); chk("r_c4_read", s_mem_read, 32'd1); chk("r_c4_addr", s_addr, 32'h40);
        step(1'b0, 1'b1); chk("r_c5_ibusy", s_ib, 32'd0); chk("r_c5_rdata", s_ird, 32'hCAFE0001);
        step(1'b0, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // memory stuck busy: forced completion after TMO access cycles
        rq_d = 1'b1; rq_drd = 1'b1; rq_dwr = 1'b0; fx_daddr = 8'h03; fx_rdata = 32'hFFFFFFFF;
        nxt_wait = 50;
        step(1'b0, 1'b1);
        for (int k = 1; k <= TMO; k++) begin
            step(1'b0, 1'b1); chk("to_acc_read", s_mem_read, 32'd1); chk("to_acc_dbusy", s_db, 32'd1);
        end
        step(1'b0, 1'b1); chk("to_dbusy", s_db, 32'd0); chk("to_dbyte", s_drd, 32'h0);
        chk("to_err", s_err, 32'd1);
        step(1'b0, 1'b1); step(1'b0, 1'b1); chk("to_err_sticky", s_err, 32'd1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1); chk("to_err_cleared", s_err, 32'd0);
`endif

        // randomized traffic with occasional resets
        use_fx = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!rq_i && ($urandom_range(0, 2) == 0)) rq_i = 1'b1;
            if (!rq_d && ($urandom_range(0, 2) == 0)) begin
                int t;
                t = $urandom_range(0, 3);
                rq_drd = (t != 2); rq_dwr = (t >= 2); rq_d = 1'b1;
            end
            nxt_wait = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
            step(($urandom_range(0, 199) == 0), 1'b1);
        end

        // drain outstanding requests within a bounded number of cycles
        nxt_wait = 0;
        for (int n = 0; n < 100 && (rq_i || rq_d || m_active); n++) step(1'b0, 1'b1);
        pend = rq_i || rq_d || m_active;
        chk("drain_done", {31'b0, pend}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_BASE, 8'hC0, memory word offset added to data-side word address.
REQ-002 Parameter TIMEOUT_CYCLES, 255, ACCESS-state cycle limit; used only under ARB_TIMEOUT_EN.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 I_READ  in  1; I_ADDR  in  32 (PC); I_READDATA  out  32; I_BUSYWAIT  out  1: instruction-fetch requester.
REQ-006 D_READ  in  1; D_WRITE  in  1; D_ADDR  in  8; D_WRITEDATA  in  8; D_READDATA  out  8; D_BUSYWAIT  out  1: data requester.
REQ-007 MEM_READ  out  1; MEM_WRITE  out  1; MEM_ADDR  out  8 (word); MEM_WRITEDATA  out  32; MEM_BYTEEN  out  4; MEM_READDATA  in  32; MEM_BUSYWAIT  in  1: shared memory port.
REQ-008 ERR  out  1: sticky access-timeout flag.

Function
REQ-009 FSM states: IDLE, ACCESS, DONE; owner register OWN in {I, D}.
REQ-010 IDLE: D request (D_READ|D_WRITE) pending -> ACCESS, OWN=D; else I_READ -> ACCESS, OWN=I; else stay; D wins every tie.
REQ-011 Address, write data, byte enables and direction latch on the IDLE->ACCESS edge and are held constant through ACCESS.
REQ-012 MEM_ADDR: OWN=I -> I_ADDR[9:2]; OWN=D -> DATA_BASE + {2'b00, D_ADDR[7:2]}, modulo 256.
REQ-013 D_READ and D_WRITE both high -> write performed, read ignored.
REQ-014 Data write: MEM_WRITEDATA = D_WRITEDATA replicated 4x; MEM_BYTEEN one-hot at D_ADDR[1:0]; reads and I fetches drive MEM_BYTEEN = 4'b1111.
REQ-015 MEM_READ/MEM_WRITE high only in ACCESS, registered, never both.
REQ-016 ACCESS -> DONE on the first edge with MEM_BUSYWAIT low; MEM_READDATA captured into a 32-bit register at that edge on reads.
REQ-017 DONE lasts exactly one cycle, then IDLE; strobes low in DONE.
REQ-018 X_BUSYWAIT = X request high AND NOT (state==DONE AND OWN==X); combinational on request inputs.
REQ-019 I_READDATA = captured word; D_READDATA = byte of captured word at latched D_ADDR[1:0]; both hold value until next capture.
REQ-020 Latency: zero-wait memory -> request at cycle 0, strobe cycle 1, BUSYWAIT low cycle 2; each memory wait cycle adds 1.
REQ-021 Requests changing during ACCESS/DONE are ignored until next IDLE; the non-owner keeps BUSYWAIT high.
REQ-022 Back-to-back: both requesters pending -> D served, then I, with exactly one IDLE cycle between.

Reset
REQ-023 RESET at any edge, including mid-ACCESS -> IDLE, OWN=I, strobes 0, MEM_ADDR/MEM_WRITEDATA 0, MEM_BYTEEN 0, captured word 0, ERR 0; in-flight access abandoned.
REQ-024 During reset cycles, I_BUSYWAIT and D_BUSYWAIT follow REQ-018 with state IDLE.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry and increments each ACCESS cycle. Counter reaching TIMEOUT_CYCLES with MEM_BUSYWAIT high forces DONE with captured word 0. ERR sets and holds until RESET.
REQ-026 ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; ERR tied 0.

Structure
REQ-027 Package mem_arb_pkg holds the state encoding, owner encoding, lane-decode constants and the DATA_BASE/TIMEOUT_CYCLES defaults.
REQ-028 Sub-module byte_lane_sel: write-data replication, MEM_BYTEEN decode and read byte select; all sequencing stays in mem_port_arbiter.

Verification
REQ-029 Zero-wait I fetch, I_ADDR=32'h8 -> MEM_ADDR=8'h02 and MEM_READ in cycle 1; I_BUSYWAIT low in cycle 2; I_READDATA=memory word.
REQ-030 D write D_ADDR=8'h05, data 8'hAB, 3 wait cycles -> MEM_ADDR=8'hC1, MEM_BYTEEN=4'b0010, MEM_WRITEDATA=32'hABABABAB; D_BUSYWAIT low in cycle 5.
REQ-031 I and D requested together -> D served first; I_BUSYWAIT held high; I served after one IDLE cycle.
REQ-032 RESET asserted during the 2nd ACCESS cycle -> next cycle IDLE, strobes 0; re-request completes normally.
REQ-033 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, MEM_BUSYWAIT stuck high -> DONE after 4 ACCESS cycles, D_READDATA=0, ERR=1 until RESET.
REQ-034 DATA_BASE=8'hFF, D_ADDR=8'h04 -> MEM_ADDR=8'h00 (wrap-around).
